dac_spi_receiver: RTL



---
 rtl/dac_spi_receiver_if.sv | 10 +
 rtl/dac_spi_receiver.sv | 116 +++++++++++
 2 files changed

// File: rtl/dac_spi_receiver_if.sv
// Shared DAC SPI bus: serial clock, data, frame select and clear, all driven by the DAC driver.
interface dac_spi_receiver_if;
    logic SPI_SCK;
    logic SPI_MOSI;
    logic DAC_CS;
    logic DAC_CLR;

    modport master (output SPI_SCK, SPI_MOSI, DAC_CS, DAC_CLR);
    modport slave  (input  SPI_SCK, SPI_MOSI, DAC_CS, DAC_CLR);
endinterface

// File: rtl/dac_spi_receiver.sv
// Passive monitor of 32-bit DAC write frames; decodes channel A/B codes into parallel registers.
module dac_spi_receiver #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DATA_W      = 12
) (
    input  logic                  CLK_50M,
    input  logic                  RST_N,
    dac_spi_receiver_if.slave     bus,
    output logic [DATA_W-1:0]     Va,
    output logic [DATA_W-1:0]     Vb,
    output logic                  va_valid,
    output logic                  vb_valid,
    output logic                  frame_err,
    output logic [3:0]            cmd_last,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    // Bus lanes {clr, cs, mosi, sck}; reset to the idle bus level.
    localparam logic [3:0] BUS_IDLE = 4'b1100;

    logic [3:0]  sync_q [SYNC_STAGES];
    logic        sck_s, mosi_s, cs_s, clr_s;
    logic        sck_prev, cs_prev;
    logic        sck_rise, cs_rise;
    logic [23:0] sr;
    logic [5:0]  bit_cnt;
    state_t      state;

    assign {clr_s, cs_s, mosi_s, sck_s} = sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign cs_rise  = cs_s & ~cs_prev;

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= BUS_IDLE;
            end
        end else begin
            sync_q[0] <= {bus.DAC_CLR, bus.DAC_CS, bus.SPI_MOSI, bus.SPI_SCK};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Only the low 24 frame bits are kept: bits [31:24] are never decoded.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b1;
            sr        <= '0;
            bit_cnt   <= '0;
            Va        <= '0;
            Vb        <= '0;
            va_valid  <= 1'b0;
            vb_valid  <= 1'b0;
            frame_err <= 1'b0;
            cmd_last  <= '0;
            busy      <= 1'b0;
        end else begin
            sck_prev  <= sck_s;
            cs_prev   <= cs_s;
            va_valid  <= 1'b0;
            vb_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!cs_s) begin
                        bit_cnt <= '0;
                        sr      <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sck_rise) begin
                        sr <= {sr[22:0], mosi_s};
                        if (bit_cnt != 6'd33) begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                    if (cs_rise) begin
                        busy  <= 1'b0;
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (bit_cnt == 6'd32) begin
                        cmd_last <= sr[23:20];
                        if (sr[23:20] == 4'b0011 && clr_s) begin
                            if (sr[19:16] == 4'h0 || sr[19:16] == 4'hF) begin
                                Va       <= sr[4 +: DATA_W];
                                va_valid <= 1'b1;
                            end
                            if (sr[19:16] == 4'h1 || sr[19:16] == 4'hF) begin
                                Vb       <= sr[4 +: DATA_W];
                                vb_valid <= 1'b1;
                            end
                        end
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Clear overrides any same-cycle commit.
            if (!clr_s) begin
                Va <= '0;
                Vb <= '0;
            end
        end
    end
endmodule
